// File: rtl/aes_pkg.sv
// Shared AES-128 constants, byte-level helpers and the FSM state type
// for the iterative inverse cipher.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Multiply by x in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // One forward step of the key schedule: K(i) -> K(i+1).
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One backward step of the key schedule: K(i+1) -> K(i).
    function automatic logic [127:0] key_inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h000000};
        return {p0, p1, p2, p3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes,
// AddRoundKey, then InvMixColumns unless this is the final round.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_i,
    input  logic [127:0] rk_i,
    input  logic         last_i,
    output logic [127:0] st_o
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    logic [127:0] sr_sb;
    logic [127:0] ark;
    logic [127:0] mixed;

    // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
    always_comb begin
        sr_sb = '0;
        mixed = '0;
        for (int i = 0; i < 16; i++) begin
            sr_sb[127 - 8*i -: 8] =
                INV_SBOX[st_i[127 - 8*(4*(((i/4) + 4 - (i%4)) % 4) + (i%4)) -: 8]];
        end
        ark = sr_sb ^ rk_i;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = inv_mix_col(ark[127 - 32*c -: 32]);
        end
        st_o = last_i ? ark : mixed;
    end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock. The key
// schedule is run forward to K10, then unwound one step per round.
// Handshake: a transfer happens on a rising edge where valid && ready;
// in_ready is high only in IDLE, out_valid holds until out_ready.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] st_q, st_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] pt_q, pt_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] cached_key_q, cached_key_d;
    logic [127:0] cached_k10_q, cached_k10_d;
    logic         cache_valid_q, cache_valid_d;

    logic         accept;
    logic         cache_hit;
    logic [127:0] rk_exp;
    logic [127:0] rk_prev;
    logic [127:0] round_out;

    assign accept    = in_valid && (state_q == IDLE);
    assign cache_hit = (KEY_CACHE != 0) && cache_valid_q && (key == cached_key_q);
    assign rk_exp    = key_expand(rk_q, RCON[cnt_q]);
    assign rk_prev   = key_inv_expand(rk_q, RCON[4'd9 - cnt_q]);

    aes_inv_round u_round (
        .st_i   (st_q),
        .rk_i   (rk_prev),
        .last_i (cnt_q == 4'd9),
        .st_o   (round_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = cache_hit ? ROUND : KEYEXP;
            KEYEXP:  if (cnt_q == 4'd9) state_d = ROUND;
            ROUND:   if (cnt_q == 4'd9) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from state and registered data only.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = out_valid_q;
        plaintext = pt_q;
    end

    // Datapath next values: capture, key schedule, rounds and the K10 cache.
    always_comb begin
        cnt_d         = cnt_q;
        rk_d          = rk_q;
        st_d          = st_q;
        ct_d          = ct_q;
        pt_d          = pt_q;
        out_valid_d   = out_valid_q;
        cached_key_d  = cached_key_q;
        cached_k10_d  = cached_k10_q;
        cache_valid_d = cache_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ct_d  = ciphertext;
                    cnt_d = 4'd0;
                    if (cache_hit) begin
                        rk_d = cached_k10_q;
                        st_d = ciphertext ^ cached_k10_q;
                    end else begin
                        rk_d = key;
                        // The key is remembered now; the entry only becomes
                        // usable once K10 has been computed for it.
                        if (KEY_CACHE != 0) begin
                            cached_key_d  = key;
                            cache_valid_d = 1'b0;
                        end
                    end
                end
            end
            KEYEXP: begin
                rk_d  = rk_exp;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    st_d  = ct_q ^ rk_exp;
                    cnt_d = 4'd0;
                    if (KEY_CACHE != 0) begin
                        cached_k10_d  = rk_exp;
                        cache_valid_d = 1'b1;
                    end
                end
            end
            ROUND: begin
                rk_d  = rk_prev;
                st_d  = round_out;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    pt_d        = round_out;
                    out_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                end
            end
            DONE: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and cache registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= 4'd0;
            rk_q          <= '0;
            st_q          <= '0;
            ct_q          <= '0;
            pt_q          <= '0;
            out_valid_q   <= 1'b0;
            cached_key_q  <= '0;
            cached_k10_q  <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rk_q          <= rk_d;
            st_q          <= st_d;
            ct_q          <= ct_d;
            pt_q          <= pt_d;
            out_valid_q   <= out_valid_d;
            cached_key_q  <= cached_key_d;
            cached_k10_q  <= cached_k10_d;
            cache_valid_q <= cache_valid_d;
        end
    end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter: known-answer vectors, latency on
// cache miss/hit, backpressure, mid-block reset, and a no-cache instance.
module tb_aes_decrypt_iter;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] KEY_SP = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT_B1  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_B2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] PT_B2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] CT_B3  = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] PT_B3  = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] CT_B4  = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] PT_B4  = 128'hf69f2445df4f9b17ad2b417be66c3710;

    logic         clk;
    logic         rst_n;
    logic         use_nc;
    logic         drv_valid;
    logic         drv_ready;
    logic [127:0] drv_key;
    logic [127:0] drv_ct;

    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] plaintext;
    logic         in_valid_n, in_ready_n, out_valid_n, out_ready_n;
    logic [127:0] plaintext_n;

    logic         sel_in_ready;
    logic         sel_out_valid;
    logic [127:0] sel_pt;

    int n_checks;
    int n_fail;

    assign in_valid      = drv_valid & ~use_nc;
    assign out_ready     = drv_ready & ~use_nc;
    assign in_valid_n    = drv_valid & use_nc;
    assign out_ready_n   = drv_ready & use_nc;
    assign sel_in_ready  = use_nc ? in_ready_n  : in_ready;
    assign sel_out_valid = use_nc ? out_valid_n : out_valid;
    assign sel_pt        = use_nc ? plaintext_n : plaintext;

    aes_decrypt_iter #(.KEY_CACHE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (drv_ct),
        .key        (drv_key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    aes_decrypt_iter #(.KEY_CACHE(0)) dut_nc (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid_n),
        .in_ready   (in_ready_n),
        .ciphertext (drv_ct),
        .key        (drv_key),
        .out_valid  (out_valid_n),
        .out_ready  (out_ready_n),
        .plaintext  (plaintext_n)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself gets stuck.
    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of test, expected end before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Submit one block, measure accept-to-out_valid latency, optionally hold
    // off the consumer for 'hold' cycles while poking in_valid, then drain.
    // Entered and left #1 after a rising edge.
    task automatic run_block(input bit nc, input logic [127:0] k, input logic [127:0] c,
                             input logic [127:0] exp_pt, input int exp_lat,
                             input int hold, input string tag);
        int lat;
        use_nc    = nc;
        check({tag, "_idle_ready"}, 128'(sel_in_ready), 128'd1);
        drv_key   = k;
        drv_ct    = c;
        drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        drv_key   = rand128();
        drv_ct    = rand128();
        check({tag, "_busy_ready"}, 128'(sel_in_ready), 128'd0);
        lat = 0;
        while (!sel_out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_pt"}, sel_pt, exp_pt);
        for (int i = 0; i < hold; i++) begin
            drv_valid = i[0];
            drv_key   = rand128();
            drv_ct    = rand128();
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 128'(sel_out_valid), 128'd1);
            check({tag, "_hold_pt"}, sel_pt, exp_pt);
            check({tag, "_hold_ready"}, 128'(sel_in_ready), 128'd0);
        end
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        @(posedge clk);
        #1;
        drv_ready = 1'b0;
        check({tag, "_drained_valid"}, 128'(sel_out_valid), 128'd0);
        check({tag, "_drained_ready"}, 128'(sel_in_ready), 128'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        use_nc    = 1'b0;
        drv_valid = 1'b0;
        drv_ready = 1'b0;
        drv_key   = '0;
        drv_ct    = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_plaintext", plaintext, 128'd0);
        check("reset_nc_in_ready", 128'(in_ready_n), 128'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known answers, all cache misses.
        run_block(1'b0, KEY_C1, CT_C1, PT_C1, 20, 0, "c1_miss");
        run_block(1'b0, 128'd0, CT_Z, 128'd0, 20, 0, "zero_key_miss");
        run_block(1'b0, KEY_SP, CT_B1, PT_B1, 20, 0, "sp_b1_miss");

        // Same key again: K10 comes from the cache.
        run_block(1'b0, KEY_SP, CT_B2, PT_B2, 10, 0, "sp_b2_hit");
        run_block(1'b0, KEY_SP, CT_B3, PT_B3, 10, 7, "sp_b3_backpressure");
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        run_block(1'b0, KEY_SP, CT_B4, PT_B4, 10, $urandom_range(0, 3), "sp_b4_gap");

        // No-cache instance never shortcuts.
        run_block(1'b1, KEY_SP, CT_B1, PT_B1, 20, 0, "nc_b1");
        run_block(1'b1, KEY_SP, CT_B2, PT_B2, 20, 0, "nc_b2_same_key");

        // A different key replaces the cache entry; the old key then misses.
        run_block(1'b0, KEY_C1, CT_C1, PT_C1, 20, 0, "c1_replace");
        run_block(1'b0, KEY_SP, CT_B2, PT_B2, 20, 0, "sp_b2_after_replace");
        run_block(1'b0, KEY_SP, CT_B1, PT_B1, 10, 0, "sp_b1_rehit");

        // Reset in the middle of a (hit) round sequence at cnt = 4.
        use_nc    = 1'b0;
        drv_key   = KEY_SP;
        drv_ct    = CT_B3;
        drv_valid = 1'b1;
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 128'(out_valid), 128'd0);
        check("midreset_plaintext", plaintext, 128'd0);
        check("midreset_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_out_valid", 128'(out_valid), 128'd0);
        run_block(1'b0, KEY_SP, CT_B4, PT_B4, 20, 0, "post_reset_miss");
        run_block(1'b0, KEY_SP, CT_B3, PT_B3, 10, 0, "post_reset_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
